// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Build option: REGFILE_WB_RR_EN selects round-robin contention handling;
// when it is undefined the load unit has fixed priority over the ALU.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Requester indices, also the encoding of the round-robin pointer
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Register 0 never reports pending. A set and a clear to the same register
// in one cycle leaves it set, since the new issue is the younger event.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_pending1,
  output logic              chk_pending2
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Next pending vector: clear first, then set so the younger issue wins
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending bits, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign chk_pending1 = pending[chk_addr1];
  assign chk_pending2 = pending[chk_addr2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and the load unit, driving a single
// registered register-file write port, plus the hazard scoreboard.
// Build option: REGFILE_WB_RR_EN -- round-robin between the two requesters
// under contention (pointer favours the ALU after reset). Without it the
// load unit always wins and no pointer register exists.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_dst_addr,
  output logic [DATA_W-1:0] rf_dst_data
);

  logic              contended;
  logic              grant_idx;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              pend1;
  logic              pend2;

`ifdef REGFILE_WB_RR_EN
  logic rr_ptr;
`endif

  // Arbitration: pick the winner, gate readies with reset, steer the winner's payload
  always_comb begin
    contended = alu_valid & lsu_valid;
`ifdef REGFILE_WB_RR_EN
    if (contended) grant_idx = rr_ptr;
    else           grant_idx = lsu_valid ? REQ_LSU : REQ_ALU;
`else
    grant_idx = lsu_valid ? REQ_LSU : REQ_ALU;
`endif
    alu_ready = !reset && alu_valid && (grant_idx == REQ_ALU);
    lsu_ready = !reset && lsu_valid && (grant_idx == REQ_LSU);
    xfer      = alu_ready | lsu_ready;
    win_addr  = (grant_idx == REQ_LSU) ? lsu_addr : alu_addr;
    win_data  = (grant_idx == REQ_LSU) ? lsu_data : alu_data;
  end

`ifdef REGFILE_WB_RR_EN
  // Round-robin pointer: after a contended grant, favour the requester that lost
  always_ff @(posedge clk) begin
    if (reset)                  rr_ptr <= REQ_ALU;
    else if (contended && xfer) rr_ptr <= ~grant_idx;
  end
`endif

  // Registered write port; writes to register 0 complete the handshake but never fire
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_en <= 1'b0;
      rf_dst_addr <= '0;
      rf_dst_data <= '0;
    end else begin
      rf_write_en <= xfer && (win_addr != '0);
      if (xfer) begin
        rf_dst_addr <= win_addr;
        rf_dst_data <= win_data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (issue_en),
    .set_addr     (issue_addr),
    .clr_en       (xfer),
    .clr_addr     (win_addr),
    .chk_addr1    (chk_addr1),
    .chk_addr2    (chk_addr2),
    .chk_pending1 (pend1),
    .chk_pending2 (pend2)
  );

  // Busy also covers the cycle where the write sits on the port but has not landed
  always_comb begin
    chk_busy1 = pend1 | (rf_write_en && (rf_dst_addr == chk_addr1) && (chk_addr1 != '0));
    chk_busy2 = pend2 | (rf_write_en && (rf_dst_addr == chk_addr2) && (chk_addr2 != '0));
  end

endmodule
